// File: rtl/rtc_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_bus_pkg
//  Purpose  : Shared types and constants for the RTC bus sequencer: FSM
//             state encoding, default strobe timing, bus width and the
//             requester-side encoding used by the round-robin arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package rtc_bus_pkg;

  localparam int unsigned AD_W  = 8;
  localparam int unsigned CNT_W = 4;

  localparam int unsigned DEF_T_SETUP   = 2;
  localparam int unsigned DEF_T_PULSE   = 10;
  localparam int unsigned DEF_T_HOLD    = 2;
  localparam int unsigned DEF_T_RECOVER = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_A_SETUP = 3'd1,
    ST_A_PULSE = 3'd2,
    ST_A_HOLD  = 3'd3,
    ST_D_SETUP = 3'd4,
    ST_D_PULSE = 3'd5,
    ST_D_HOLD  = 3'd6,
    ST_RECOVER = 3'd7
  } state_t;

  typedef enum logic {
    SIDE_READ  = 1'b0,
    SIDE_WRITE = 1'b1
  } side_t;

  // Round-robin helper: the side that was not served last.
  function automatic side_t other_side(input side_t s);
    return (s == SIDE_READ) ? SIDE_WRITE : SIDE_READ;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_bus_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_bus_sequencer_if
//  Purpose  : Requester handshakes and RTC pin bundle. The master modport is
//             the sequencer's view (it owns the bus); the slave modport is
//             the view of the requesters and the pads.
//  Revision : 1.0 - initial release
// ============================================================================
interface rtc_bus_sequencer_if;
  import rtc_bus_pkg::*;

  logic            en;
  logic            w_req;
  logic [AD_W-1:0] w_addr;
  logic [AD_W-1:0] w_data;
  logic            w_ack;
  logic            r_req;
  logic [AD_W-1:0] r_addr;
  logic [AD_W-1:0] r_data;
  logic            r_valid;
  logic            busy;
  logic            cs_n;
  logic            wr_n;
  logic            rd_n;
  logic            ad_sel;
  logic [AD_W-1:0] ad_out;
  logic            ad_oe;
  logic [AD_W-1:0] ad_in;

  modport master (
    input  en, w_req, w_addr, w_data, r_req, r_addr, ad_in,
    output w_ack, r_data, r_valid, busy, cs_n, wr_n, rd_n, ad_sel, ad_out, ad_oe
  );

  modport slave (
    output en, w_req, w_addr, w_data, r_req, r_addr, ad_in,
    input  w_ack, r_data, r_valid, busy, cs_n, wr_n, rd_n, ad_sel, ad_out, ad_oe
  );

endinterface
`default_nettype wire

// File: rtl/rtc_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_phase_timer
//  Purpose  : Loadable down-counter timing each bus phase. Loaded with
//             (length-1) on phase entry; done is high once it reaches zero.
//  Revision : 1.0 - initial release
// ============================================================================
module rtc_phase_timer
  import rtc_bus_pkg::*;
(
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Reload on phase entry, otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/rtc_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_bus_sequencer
//  Purpose  : Sole driver of the RTC multiplexed address/data bus. Arbitrates
//             between the write and periodic-read requesters (round-robin on
//             ties) and generates chip-select, address-phase and data-phase
//             strobe timing. Every output is registered from the next state.
//  Revision : 1.0 - initial release
// ============================================================================
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_SETUP   = DEF_T_SETUP,
  parameter int unsigned T_PULSE   = DEF_T_PULSE,
  parameter int unsigned T_HOLD    = DEF_T_HOLD,
  parameter int unsigned T_RECOVER = DEF_T_RECOVER
) (
  input  logic                clk,
  input  logic                Reset_n,
  rtc_bus_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] PULSE_LD   = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(T_RECOVER - 1);

  state_t          state_q, state_d;
  side_t           last_q, last_d;
  side_t           dir_q, dir_d;
  side_t           pick;
  logic [AD_W-1:0] addr_q, addr_d;
  logic [AD_W-1:0] data_q, data_d;

  logic            cs_n_q, cs_n_d;
  logic            wr_n_q, wr_n_d;
  logic            rd_n_q, rd_n_d;
  logic            ad_sel_q, ad_sel_d;
  logic            ad_oe_q, ad_oe_d;
  logic [AD_W-1:0] ad_out_q, ad_out_d;
  logic [AD_W-1:0] r_data_q, r_data_d;
  logic            w_ack_q, w_ack_d;
  logic            r_valid_q, r_valid_d;
  logic            busy_q, busy_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  // Phase length (minus one) for the phase being entered.
  function automatic logic [CNT_W-1:0] phase_load(input state_t s);
    logic [CNT_W-1:0] v;
    v = '0;
    case (s)
      ST_A_SETUP, ST_D_SETUP: v = SETUP_LD;
      ST_A_PULSE, ST_D_PULSE: v = PULSE_LD;
      ST_A_HOLD,  ST_D_HOLD:  v = HOLD_LD;
      ST_RECOVER:             v = RECOVER_LD;
      default:                v = '0;
    endcase
    return v;
  endfunction

  // The timer restarts whenever the FSM moves to a different state
  assign tmr_load = (state_d != state_q);
  assign tmr_val  = phase_load(state_d);

  rtc_phase_timer u_timer (
    .clk        (clk),
    .Reset_n    (Reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Arbitration in IDLE and phase sequencing on timer expiry
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pick    = SIDE_READ;
    case (state_q)
      ST_IDLE: begin
        if (bus.en && (bus.w_req || bus.r_req)) begin
          if (bus.w_req && bus.r_req) begin
            pick = other_side(last_q);
          end else if (bus.w_req) begin
            pick = SIDE_WRITE;
          end else begin
            pick = SIDE_READ;
          end
          state_d = ST_A_SETUP;
          last_d  = pick;
          dir_d   = pick;
          addr_d  = (pick == SIDE_WRITE) ? bus.w_addr : bus.r_addr;
          data_d  = bus.w_data;
        end
      end
      ST_A_SETUP: if (tmr_done) state_d = ST_A_PULSE;
      ST_A_PULSE: if (tmr_done) state_d = ST_A_HOLD;
      ST_A_HOLD:  if (tmr_done) state_d = ST_D_SETUP;
      ST_D_SETUP: if (tmr_done) state_d = ST_D_PULSE;
      ST_D_PULSE: if (tmr_done) state_d = ST_D_HOLD;
      ST_D_HOLD:  if (tmr_done) state_d = ST_RECOVER;
      ST_RECOVER: if (tmr_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Pin values for the upcoming state; ad_out/ad_sel only move in SETUP
  always_comb begin
    cs_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    rd_n_d    = 1'b1;
    ad_oe_d   = 1'b0;
    ad_sel_d  = ad_sel_q;
    ad_out_d  = ad_out_q;
    case (state_d)
      ST_A_SETUP: begin
        cs_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_sel_d = 1'b0;
        ad_out_d = addr_d;
      end
      ST_A_PULSE: begin
        cs_n_d  = 1'b0;
        ad_oe_d = 1'b1;
        wr_n_d  = 1'b0;
      end
      ST_A_HOLD: begin
        cs_n_d  = 1'b0;
        ad_oe_d = 1'b1;
      end
      ST_D_SETUP: begin
        cs_n_d   = 1'b0;
        ad_sel_d = 1'b1;
        ad_oe_d  = (dir_d == SIDE_WRITE);
        if (dir_d == SIDE_WRITE) ad_out_d = data_d;
      end
      ST_D_PULSE: begin
        cs_n_d  = 1'b0;
        ad_oe_d = (dir_d == SIDE_WRITE);
        if (dir_d == SIDE_WRITE) wr_n_d = 1'b0;
        else                     rd_n_d = 1'b0;
      end
      ST_D_HOLD: begin
        cs_n_d  = 1'b0;
        ad_oe_d = (dir_d == SIDE_WRITE);
      end
      default: ;
    endcase

    // Completion pulses line up with the first RECOVER cycle
    w_ack_d   = (state_q == ST_D_HOLD) && (state_d == ST_RECOVER) && (dir_q == SIDE_WRITE);
    r_valid_d = (state_q == ST_D_HOLD) && (state_d == ST_RECOVER) && (dir_q == SIDE_READ);
    busy_d    = (state_d != ST_IDLE);

    // Read data is sampled on the final cycle rd_n is low
    r_data_d = r_data_q;
    if ((state_q == ST_D_PULSE) && tmr_done && (dir_q == SIDE_READ)) begin
      r_data_d = bus.ad_in;
    end
  end

  // FSM state, arbitration history and latched transaction
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= SIDE_READ;
      dir_q   <= SIDE_READ;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cs_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      ad_sel_q  <= 1'b1;
      ad_oe_q   <= 1'b0;
      ad_out_q  <= '0;
      r_data_q  <= '0;
      w_ack_q   <= 1'b0;
      r_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      cs_n_q    <= cs_n_d;
      wr_n_q    <= wr_n_d;
      rd_n_q    <= rd_n_d;
      ad_sel_q  <= ad_sel_d;
      ad_oe_q   <= ad_oe_d;
      ad_out_q  <= ad_out_d;
      r_data_q  <= r_data_d;
      w_ack_q   <= w_ack_d;
      r_valid_q <= r_valid_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.cs_n    = cs_n_q;
  assign bus.wr_n    = wr_n_q;
  assign bus.rd_n    = rd_n_q;
  assign bus.ad_sel  = ad_sel_q;
  assign bus.ad_oe   = ad_oe_q;
  assign bus.ad_out  = ad_out_q;
  assign bus.r_data  = r_data_q;
  assign bus.w_ack   = w_ack_q;
  assign bus.r_valid = r_valid_q;
  assign bus.busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rtc_bus_sequencer
//  Purpose  : Directed self-checking bench for rtc_bus_sequencer. One DUT
//             uses default timing, a second uses all-ones timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_sequencer;
  import rtc_bus_pkg::*;

  logic clk = 1'b0;
  logic Reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  rtc_bus_sequencer_if a ();
  rtc_bus_sequencer_if f ();

  rtc_bus_sequencer #(
    .T_SETUP(2), .T_PULSE(10), .T_HOLD(2), .T_RECOVER(4)
  ) u_dut (
    .clk(clk), .Reset_n(Reset_n), .bus(a)
  );

  rtc_bus_sequencer #(
    .T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_RECOVER(1)
  ) u_fast (
    .clk(clk), .Reset_n(Reset_n), .bus(f)
  );

  // Observations gathered while a transaction runs on the default DUT
  int        busy_rise[$];
  int        ack_t[$];
  int        ack_side[$];
  int        wr_len[$];
  int        rd_len[$];
  logic [7:0] wr_ad[$];
  int        cs_low;
  int        oe_data_cnt;
  int        strobe_ad_bad;
  logic [7:0] rdata_seen;
  bit        timed_out;

  // Runs the default DUT cycle by cycle (sampling at negedge), playing the
  // RTC chip on ad_in and optionally dropping requests on their ack.
  task automatic watch(input int limit, input int n_acks, input bit drop_w, input bit drop_r);
    logic       pb, pw, pr, ps;
    logic [7:0] pad;
    int         acks;
    busy_rise.delete(); ack_t.delete(); ack_side.delete();
    wr_len.delete(); rd_len.delete(); wr_ad.delete();
    cs_low = 0; oe_data_cnt = 0; strobe_ad_bad = 0; rdata_seen = 8'h00;
    timed_out = 1'b1; acks = 0;
    pb = a.busy; pw = a.wr_n; pr = a.rd_n; ps = a.ad_sel; pad = a.ad_out;
    for (int t = 0; t < limit; t++) begin
      @(negedge clk);
      if (a.busy && !pb) busy_rise.push_back(t);
      if (!a.cs_n) cs_low++;
      if (!a.cs_n && a.ad_sel && a.ad_oe) oe_data_cnt++;
      if (!a.wr_n) begin
        if (pw) begin wr_len.push_back(0); wr_ad.push_back(a.ad_out); end
        wr_len[wr_len.size()-1] = wr_len[wr_len.size()-1] + 1;
      end
      if (!a.rd_n) begin
        if (pr) rd_len.push_back(0);
        rd_len[rd_len.size()-1] = rd_len[rd_len.size()-1] + 1;
      end
      if ((!a.wr_n || !a.rd_n) && (!pw || !pr) && (a.ad_out !== pad || a.ad_sel !== ps))
        strobe_ad_bad++;
      if (a.w_ack) begin
        ack_t.push_back(t); ack_side.push_back(1); acks++;
        if (drop_w) a.w_req = 1'b0;
      end
      if (a.r_valid) begin
        ack_t.push_back(t); ack_side.push_back(0); acks++;
        rdata_seen = a.r_data;
        if (drop_r) a.r_req = 1'b0;
      end
      a.ad_in = (!a.rd_n) ? 8'h37 : 8'hFF;
      pb = a.busy; pw = a.wr_n; pr = a.rd_n; ps = a.ad_sel; pad = a.ad_out;
      if (acks >= n_acks && !a.busy) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    a.en = 1'b1; a.w_req = 1'b0; a.r_req = 1'b0;
    a.w_addr = 8'h00; a.w_data = 8'h00; a.r_addr = 8'h00; a.ad_in = 8'hFF;
    f.en = 1'b1; f.w_req = 1'b0; f.r_req = 1'b0;
    f.w_addr = 8'h00; f.w_data = 8'h00; f.r_addr = 8'h00; f.ad_in = 8'hFF;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({a.cs_n, a.wr_n, a.rd_n, a.ad_sel, a.ad_oe, a.w_ack, a.r_valid, a.busy} !== 8'b1111_0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 11110000",
               {a.cs_n, a.wr_n, a.rd_n, a.ad_sel, a.ad_oe, a.w_ack, a.r_valid, a.busy});
    end
    n_tests++;
    if ({a.ad_out, a.r_data} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0000", {a.ad_out, a.r_data});
    end
    n_tests++;
    if ({f.cs_n, f.wr_n, f.rd_n, f.ad_sel, f.ad_oe, f.w_ack, f.r_valid, f.busy} !== 8'b1111_0000) begin
      n_fail++;
      $display("FAIL reset_fast_ctrl: got %b expected 11110000",
               {f.cs_n, f.wr_n, f.rd_n, f.ad_sel, f.ad_oe, f.w_ack, f.r_valid, f.busy});
    end
    Reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_contention();
    int code;
    a.w_addr = 8'h33; a.w_data = 8'h99; a.r_addr = 8'h44;
    a.w_req = 1'b1; a.r_req = 1'b1;
    watch(200, 3, 1'b0, 1'b1);
    a.w_req = 1'b0;
    n_tests++;
    if (timed_out) begin n_fail++; $display("FAIL cont_timeout: got timeout expected 3 acks"); end
    n_tests++;
    if (ack_side.size() != 3) begin
      n_fail++; $display("FAIL cont_ack_count: got %0d expected 3", ack_side.size());
    end else begin
      code = ack_side[0] * 4 + ack_side[1] * 2 + ack_side[2];
      n_tests++;
      if (code != 5) begin n_fail++; $display("FAIL cont_order: got %b expected 101 (W,R,W)", code[2:0]); end
    end
    n_tests++;
    if (busy_rise.size() != 3) begin
      n_fail++; $display("FAIL cont_grants: got %0d expected 3", busy_rise.size());
    end else begin
      n_tests++;
      if (busy_rise[1] - busy_rise[0] != 33 || busy_rise[2] - busy_rise[1] != 33) begin
        n_fail++;
        $display("FAIL cont_spacing: got %0d,%0d expected 33,33",
                 busy_rise[1] - busy_rise[0], busy_rise[2] - busy_rise[1]);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_lone_write();
    a.w_addr = 8'h21; a.w_data = 8'h45; a.w_req = 1'b1;
    watch(100, 1, 1'b1, 1'b0);
    n_tests++;
    if (timed_out) begin n_fail++; $display("FAIL wr_timeout: got timeout expected ack"); end
    n_tests++;
    if (cs_low != 28) begin n_fail++; $display("FAIL wr_cs_low: got %0d expected 28", cs_low); end
    n_tests++;
    if (wr_len.size() != 2 || rd_len.size() != 0) begin
      n_fail++; $display("FAIL wr_pulses: got wr=%0d rd=%0d expected wr=2 rd=0", wr_len.size(), rd_len.size());
    end else begin
      n_tests++;
      if (wr_len[0] != 10 || wr_len[1] != 10) begin
        n_fail++; $display("FAIL wr_pulse_len: got %0d,%0d expected 10,10", wr_len[0], wr_len[1]);
      end
      n_tests++;
      if (wr_ad[0] !== 8'h21 || wr_ad[1] !== 8'h45) begin
        n_fail++; $display("FAIL wr_ad_out: got %h,%h expected 21,45", wr_ad[0], wr_ad[1]);
      end
    end
    n_tests++;
    if (busy_rise.size() != 1 || ack_t.size() != 1) begin
      n_fail++; $display("FAIL wr_events: got rise=%0d ack=%0d expected 1,1", busy_rise.size(), ack_t.size());
    end else begin
      n_tests++;
      if (busy_rise[0] != 0) begin
        n_fail++; $display("FAIL wr_grant_latency: got %0d expected 0", busy_rise[0]);
      end
      n_tests++;
      if (ack_t[0] - busy_rise[0] != 28) begin
        n_fail++; $display("FAIL wr_ack_time: got grant+%0d expected grant+29", ack_t[0] - busy_rise[0] + 1);
      end
    end
    n_tests++;
    if (oe_data_cnt != 14) begin n_fail++; $display("FAIL wr_data_oe: got %0d expected 14", oe_data_cnt); end
    n_tests++;
    if (strobe_ad_bad != 0) begin n_fail++; $display("FAIL wr_ad_stable: got %0d expected 0", strobe_ad_bad); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lone_read();
    a.r_addr = 8'h22; a.r_req = 1'b1;
    watch(100, 1, 1'b0, 1'b1);
    n_tests++;
    if (timed_out) begin n_fail++; $display("FAIL rd_timeout: got timeout expected r_valid"); end
    n_tests++;
    if (rd_len.size() != 1 || wr_len.size() != 1) begin
      n_fail++; $display("FAIL rd_pulses: got rd=%0d wr=%0d expected 1,1", rd_len.size(), wr_len.size());
    end else begin
      n_tests++;
      if (rd_len[0] != 10) begin n_fail++; $display("FAIL rd_pulse_len: got %0d expected 10", rd_len[0]); end
      n_tests++;
      if (wr_ad[0] !== 8'h22) begin n_fail++; $display("FAIL rd_addr: got %h expected 22", wr_ad[0]); end
    end
    n_tests++;
    if (oe_data_cnt != 0) begin n_fail++; $display("FAIL rd_data_oe: got %0d expected 0", oe_data_cnt); end
    n_tests++;
    if (ack_side.size() != 1) begin
      n_fail++; $display("FAIL rd_valid_count: got %0d expected 1", ack_side.size());
    end else begin
      n_tests++;
      if (ack_side[0] != 0 || ack_t[0] - busy_rise[0] != 28) begin
        n_fail++; $display("FAIL rd_valid: got side=%0d offs=%0d expected side=0 offs=28",
                           ack_side[0], ack_t[0] - busy_rise[0]);
      end
    end
    n_tests++;
    if (rdata_seen !== 8'h37) begin n_fail++; $display("FAIL rd_data: got %h expected 37", rdata_seen); end
    repeat (2) @(negedge clk);
    n_tests++;
    if (a.r_data !== 8'h37) begin n_fail++; $display("FAIL rd_data_hold: got %h expected 37", a.r_data); end
  endtask

  task automatic test_reset_mid();
    int k;
    int acks_seen;
    int bad_idle;
    a.w_addr = 8'h55; a.w_data = 8'h66; a.w_req = 1'b1;
    k = 0;
    while (a.wr_n !== 1'b0 && k < 50) begin @(negedge clk); k++; end
    n_tests++;
    if (a.wr_n !== 1'b0) begin n_fail++; $display("FAIL rst_mid_reach: got wr_n=%b expected 0", a.wr_n); end
    #2 Reset_n = 1'b0;
    #1;
    n_tests++;
    if ({a.cs_n, a.wr_n, a.ad_oe, a.busy, a.ad_sel} !== 5'b11001 || a.ad_out !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got cs=%b wr=%b oe=%b busy=%b sel=%b ad=%h expected 1 1 0 0 1 00",
               a.cs_n, a.wr_n, a.ad_oe, a.busy, a.ad_sel, a.ad_out);
    end
    a.w_req = 1'b0;
    acks_seen = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (a.w_ack) acks_seen++; end
    Reset_n = 1'b1;
    bad_idle = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a.w_ack) acks_seen++;
      if (a.busy || !a.cs_n) bad_idle++;
    end
    n_tests++;
    if (acks_seen != 0) begin n_fail++; $display("FAIL rst_mid_no_ack: got %0d expected 0", acks_seen); end
    n_tests++;
    if (bad_idle != 0) begin n_fail++; $display("FAIL rst_mid_idle: got %0d busy cycles expected 0", bad_idle); end
  endtask

  task automatic test_enable_gating();
    int k;
    int busy_cnt;
    a.r_addr = 8'h10; a.r_req = 1'b1; a.en = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!a.busy && k < 20);
    n_tests++;
    if (a.busy !== 1'b1) begin n_fail++; $display("FAIL gate_read_grant: got busy=%b expected 1", a.busy); end
    a.en = 1'b0;
    a.w_addr = 8'h30; a.w_data = 8'h5A; a.w_req = 1'b1;
    watch(100, 1, 1'b0, 1'b1);
    n_tests++;
    if (timed_out || ack_side.size() != 1) begin
      n_fail++; $display("FAIL gate_read_done: got acks=%0d expected 1", ack_side.size());
    end else begin
      n_tests++;
      if (ack_side[0] != 0 || rdata_seen !== 8'h37) begin
        n_fail++; $display("FAIL gate_read_data: got side=%0d data=%h expected 0,37", ack_side[0], rdata_seen);
      end
    end
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (a.busy) busy_cnt++; end
    n_tests++;
    if (busy_cnt != 0) begin n_fail++; $display("FAIL gate_hold_off: got %0d busy cycles expected 0", busy_cnt); end
    a.en = 1'b1;
    @(negedge clk);
    n_tests++;
    if (a.busy !== 1'b1) begin n_fail++; $display("FAIL gate_release: got busy=%b expected 1", a.busy); end
    watch(100, 1, 1'b1, 1'b0);
    n_tests++;
    if (timed_out || ack_side.size() != 1 || wr_ad.size() != 2) begin
      n_fail++; $display("FAIL gate_write_done: got acks=%0d pulses=%0d expected 1,2", ack_side.size(), wr_ad.size());
    end else begin
      n_tests++;
      if (ack_side[0] != 1 || wr_ad[0] !== 8'h30 || wr_ad[1] !== 8'h5A) begin
        n_fail++; $display("FAIL gate_write: got side=%0d ad=%h,%h expected 1,30,5a", ack_side[0], wr_ad[0], wr_ad[1]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fast_timing();
    int   rise[$];
    int   cs_cnt;
    int   ack_at;
    logic pb;
    cs_cnt = 0; ack_at = -1;
    f.w_addr = 8'h0F; f.w_data = 8'hF0; f.w_req = 1'b1;
    pb = f.busy;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (f.busy && !pb) rise.push_back(t);
      if (!f.cs_n && rise.size() == 1) cs_cnt++;
      if (f.w_ack && ack_at < 0) ack_at = t;
      if (rise.size() == 2) f.w_req = 1'b0;
      pb = f.busy;
    end
    f.w_req = 1'b0;
    n_tests++;
    if (rise.size() != 2) begin
      n_fail++; $display("FAIL fast_grants: got %0d expected 2", rise.size());
    end else begin
      n_tests++;
      if (rise[1] - rise[0] != 8) begin
        n_fail++; $display("FAIL fast_spacing: got %0d expected 8", rise[1] - rise[0]);
      end
      n_tests++;
      if (ack_at - rise[0] != 6) begin
        n_fail++; $display("FAIL fast_ack: got grant+%0d expected grant+7", ack_at - rise[0] + 1);
      end
    end
    n_tests++;
    if (cs_cnt != 6) begin n_fail++; $display("FAIL fast_cs_low: got %0d expected 6", cs_cnt); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_lone_write();
    test_lone_read();
    test_reset_mid();
    test_enable_gating();
    test_fast_timing();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
